// File: rtl/shift_sched.sv
// shift_sched: round-robin scheduler for two requesters sharing one
// left-shift register driven through a save/left request-completion handshake.
module shift_sched #(
    parameter int Width   = 32,
    parameter int ShAmtW  = 5,
    parameter int Settle  = 3,
    parameter int Timeout = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              b_req,
    input  logic [Width-1:0]  a_data,
    input  logic [Width-1:0]  b_data,
    input  logic [ShAmtW-1:0] a_shamt,
    input  logic [ShAmtW-1:0] b_shamt,
    output logic              a_done,
    output logic              b_done,
    output logic              a_err,
    output logic              b_err,
    output logic [Width-1:0]  result,
    output logic              save_req,
    output logic              left_req,
    input  logic              save_fin,
    input  logic              left_fin,
    output logic [Width-1:0]  reg_in,
    input  logic [Width-1:0]  reg_out
);

    localparam int CW = $clog2(Timeout + 1);
    localparam logic [CW-1:0] SettleLast  = CW'(Settle - 1);
    localparam logic [CW-1:0] TimeoutLast = CW'(Timeout - 1);

    typedef enum logic [2:0] {
        IDLE, SAVE, SAVE_REL, SHIFT, SHIFT_REL, DONE
    } state_t;

    state_t            st, nxt;
    logic [1:0]        save_sync, left_sync;
    logic [CW-1:0]     cyc;
    logic [ShAmtW-1:0] shcnt;
    logic              owner_b, prio_b;
    logic              grant, pick_b, abort;
    logic              save_ok, left_ok;

    assign save_ok = save_sync[1];
    assign left_ok = left_sync[1];

    // Two-flop synchronizers for the asynchronous completion levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            save_sync <= '0;
            left_sync <= '0;
        end else begin
            save_sync <= {save_sync[0], save_fin};
            left_sync <= {left_sync[0], left_fin};
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= IDLE;
        else     st <= nxt;
    end

    // Next-state, grant selection and timeout detection
    always_comb begin
        nxt    = st;
        grant  = 1'b0;
        pick_b = 1'b0;
        abort  = 1'b0;
        case (st)
            IDLE: begin
                if (a_req || b_req) begin
                    grant  = 1'b1;
                    pick_b = b_req && (!a_req || prio_b);
                    nxt    = SAVE;
                end
            end
            SAVE: begin
                if (cyc >= SettleLast && save_ok) begin
                    nxt = SAVE_REL;
                end else if (cyc >= TimeoutLast) begin
                    abort = 1'b1;
                    nxt   = DONE;
                end
            end
            SAVE_REL: nxt = (shcnt != '0) ? SHIFT : DONE;
            SHIFT: begin
                if (cyc >= SettleLast && left_ok) begin
                    nxt = SHIFT_REL;
                end else if (cyc >= TimeoutLast) begin
                    abort = 1'b1;
                    nxt   = DONE;
                end
            end
            SHIFT_REL: nxt = (shcnt != ShAmtW'(1)) ? SHIFT : DONE;
            DONE:      nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end

    // Registered register commands and per-phase cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            save_req <= 1'b0;
            left_req <= 1'b0;
            cyc      <= '0;
        end else begin
            save_req <= (nxt == SAVE);
            left_req <= (nxt == SHIFT);
            if ((st == SAVE || st == SHIFT) && nxt == st) cyc <= cyc + CW'(1);
            else                                          cyc <= '0;
        end
    end

    // Grant capture, round-robin pointer and shift-count tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_b <= 1'b0;
            prio_b  <= 1'b0;
            reg_in  <= '0;
            shcnt   <= '0;
        end else if (grant) begin
            owner_b <= pick_b;
            prio_b  <= !pick_b;
            reg_in  <= pick_b ? b_data : a_data;
            shcnt   <= pick_b ? b_shamt : a_shamt;
        end else if (st == SHIFT_REL) begin
            shcnt   <= shcnt - ShAmtW'(1);
        end
    end

    // Completion pulses and result capture on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_done <= 1'b0;
            b_done <= 1'b0;
            a_err  <= 1'b0;
            b_err  <= 1'b0;
            result <= '0;
        end else begin
            a_done <= (nxt == DONE) && !owner_b;
            b_done <= (nxt == DONE) && owner_b;
            a_err  <= abort && !owner_b;
            b_err  <= abort && owner_b;
            if (nxt == DONE) result <= abort ? '0 : reg_out;
        end
    end

endmodule

// File: tb/tb_shift_sched.sv
// tb_shift_sched: directed scoreboard bench for shift_sched with a
// behavioural shift-register model and a per-cycle protocol monitor.
module tb_shift_sched;

    localparam int W  = 8;
    localparam int SW = 4;
    localparam int ST = 3;
    localparam int TO = 64;

    typedef struct {
        logic         b;
        logic [W-1:0] res;
        logic         err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, b_req;
    logic [W-1:0]  a_data, b_data;
    logic [SW-1:0] a_shamt, b_shamt;
    logic          a_done, b_done, a_err, b_err;
    logic [W-1:0]  result;
    logic          save_req, left_req;
    logic          save_fin = 1'b0;
    logic          left_fin = 1'b0;
    logic [W-1:0]  reg_in;
    logic [W-1:0]  reg_val = '0;

    logic sp = 1'b0, lp = 1'b0;
    logic mp_s = 1'b0, mp_l = 1'b0;
    logic hang_left = 1'b0;
    int   save_rises = 0, left_rises = 0;
    int   done_cnt = 0, proto_err = 0;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail = 0;

    shift_sched #(
        .Width(W), .ShAmtW(SW), .Settle(ST), .Timeout(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .b_req(b_req),
        .a_data(a_data), .b_data(b_data),
        .a_shamt(a_shamt), .b_shamt(b_shamt),
        .a_done(a_done), .b_done(b_done),
        .a_err(a_err), .b_err(b_err),
        .result(result),
        .save_req(save_req), .left_req(left_req),
        .save_fin(save_fin), .left_fin(left_fin),
        .reg_in(reg_in), .reg_out(reg_val)
    );

    always #5 clk = ~clk;

    // Register model: acts on command rising edges, completes one cycle later
    always @(posedge clk) begin
        sp <= save_req;
        lp <= left_req;
        if (save_req && !sp) reg_val <= reg_in;
        if (left_req && !lp) reg_val <= reg_val << 1;
        save_fin <= save_req;
        left_fin <= left_req && !hang_left;
    end

    // Protocol monitor and event counters, sampled mid-cycle
    always @(negedge clk) begin
        mp_s <= save_req;
        mp_l <= left_req;
        if (save_req && !mp_s) save_rises <= save_rises + 1;
        if (left_req && !mp_l) left_rises <= left_rises + 1;
        if (a_done || b_done) done_cnt <= done_cnt + 1;
        if ((save_req && left_req) || (a_done && b_done) ||
            (a_err && !a_done) || (b_err && !b_done))
            proto_err <= proto_err + 1;
    end

    function automatic logic [W-1:0] model(input logic [W-1:0] d,
                                           input int sh);
        logic [W-1:0] v;
        v = d;
        for (int i = 0; i < sh; i++) v = {v[W-2:0], 1'b0};
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic [W-1:0] d, input int sh);
        a_data  = d;
        a_shamt = SW'(sh);
        a_req   = 1'b1;
        sb.push_back('{1'b0, model(d, sh), 1'b0});
    endtask

    task automatic drive_b(input logic [W-1:0] d, input int sh);
        b_data  = d;
        b_shamt = SW'(sh);
        b_req   = 1'b1;
        sb.push_back('{1'b1, model(d, sh), 1'b0});
    endtask

    task automatic wait_done(input int bound, output int cycles);
        exp_t e;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!(a_done || b_done) && cycles < bound);
        chk("done_seen", {31'b0, a_done || b_done}, 1);
        if (!(a_done || b_done)) return;
        chk("sb_nonempty", {31'b0, sb.size() != 0}, 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("who_b", {31'b0, b_done}, {31'b0, e.b});
        chk("result", {24'b0, result}, {24'b0, e.res});
        chk("err", {31'b0, a_err | b_err}, {31'b0, e.err});
        if (a_done) a_req = 1'b0;
        if (b_done) b_req = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int cyc, s0, l0, d0, k;
        rst = 1'b1;
        a_req = 0; b_req = 0;
        a_data = '0; b_data = '0;
        a_shamt = '0; b_shamt = '0;
        repeat (3) @(negedge clk);
        chk("rst_save_req", {31'b0, save_req}, 0);
        chk("rst_left_req", {31'b0, left_req}, 0);
        chk("rst_done", {30'b0, a_done, b_done}, 0);
        chk("rst_err", {30'b0, a_err, b_err}, 0);
        chk("rst_result", {24'b0, result}, 0);
        chk("rst_reg_in", {24'b0, reg_in}, 0);
        rst = 1'b0;
        @(negedge clk);

        // basic load + two shifts
        #1 s0 = save_rises; l0 = left_rises;
        drive_a(8'h0B, 2);
        wait_done(2000, cyc);
        chk("latency_min", {31'b0, cyc >= (2 + 1) * (ST + 1) + 2}, 1);
        #1;
        chk("t1_saves", save_rises - s0, 1);
        chk("t1_shifts", left_rises - l0, 2);

        // round robin: after reset A first, then B
        pulse_rst();
        drive_a(8'h81, 1);
        drive_b(8'h03, 3);
        wait_done(2000, cyc);
        wait_done(2000, cyc);
        // lone A, then a tie must go to B
        drive_a(8'h40, 1);
        wait_done(2000, cyc);
        drive_b(8'h01, 2);
        drive_a(8'h10, 0);
        wait_done(2000, cyc);
        wait_done(2000, cyc);

        // shamt 0: load only
        #1 s0 = save_rises; l0 = left_rises;
        drive_a(8'hA5, 0);
        wait_done(2000, cyc);
        #1;
        chk("sh0_saves", save_rises - s0, 1);
        chk("sh0_shifts", left_rises - l0, 0);

        // shamt beyond width: all shifts execute, result 0
        #1 l0 = left_rises;
        drive_b(8'hFF, 9);
        wait_done(3000, cyc);
        #1;
        chk("big_shifts", left_rises - l0, 9);

        // left_fin never arrives: timeout with err on B
        hang_left = 1'b1;
        b_data = 8'h11;
        b_shamt = SW'(1);
        b_req = 1'b1;
        sb.push_back('{1'b1, 8'h00, 1'b1});
        wait_done(3000, cyc);
        chk("to_left_low", {31'b0, left_req}, 0);
        chk("to_b_err", {31'b0, b_err}, 1);
        chk("to_min_wait", {31'b0, cyc >= TO}, 1);
        hang_left = 1'b0;
        repeat (3) @(negedge clk);

        // reset in the middle of a shift
        a_data = 8'h0F;
        a_shamt = SW'(3);
        a_req = 1'b1;
        k = 0;
        while (!left_req && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("mid_left_seen", {31'b0, left_req}, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_save", {31'b0, save_req}, 0);
        chk("mid_rst_left", {31'b0, left_req}, 0);
        d0 = done_cnt;
        a_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("mid_no_done", done_cnt - d0, 0);

        // fresh op after reset; request dropped early must still finish
        s0 = save_rises; l0 = left_rises;
        drive_a(8'h05, 1);
        k = 0;
        while (!save_req && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("fresh_save_first", {30'b0, save_req, left_req}, 2);
        a_req = 1'b0;
        wait_done(2000, cyc);
        #1;
        chk("fresh_saves", save_rises - s0, 1);
        chk("fresh_shifts", left_rises - l0, 1);

        repeat (4) @(negedge clk);
        chk("protocol", proto_err, 0);
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 Width, default 32, data width of requester operands and of the shared left-shift register.
REQ-002 ShAmtW, default 5, width of the shift-amount fields.
REQ-003 Settle, default 3, minimum cycles a register request stays high before completion is accepted (>=2).
REQ-004 Timeout, default 64, cycles a register request may wait for completion before it is aborted.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 a_req, b_req  in  1 each  requester A/B operation request, level, held until the matching done pulse.
REQ-008 a_data, b_data  in  Width each  value to load; sampled on grant.
REQ-009 a_shamt, b_shamt  in  ShAmtW each  number of single-bit left shifts; sampled on grant.
REQ-010 a_done, b_done  out  1 each  one-cycle completion pulse.
REQ-011 a_err, b_err  out  1 each  one-cycle pulse coincident with done when the operation was aborted.
REQ-012 result  out  Width  shifted value; valid in the cycle done pulses, held until the next done.
REQ-013 save_req, left_req  out  1 each  register load/shift requests, registered, rising edge = command.
REQ-014 save_fin, left_fin  in  1 each  register completion levels, asynchronous to clk.
REQ-015 reg_in  out  Width  load value presented to the register.
REQ-016 reg_out  in  Width  register contents.

Function
REQ-017 save_fin and left_fin SHALL each pass a 2-flop synchronizer before use; only the synchronized level is examined.
REQ-018 FSM states SHALL be IDLE, SAVE, SAVE_REL, SHIFT, SHIFT_REL, DONE.
REQ-019 IDLE: if any request is high, the block SHALL grant one, capture its data into reg_in, capture its shamt into a down-counter, and enter SAVE.
REQ-020 Arbitration SHALL be round-robin: when both requests are high, the requester not granted last wins; after reset A wins.
REQ-021 SAVE: save_req=1; a cycle counter SHALL start at 0 on entry; exit to SAVE_REL when counter>=Settle-1 and synchronized save_fin=1.
REQ-022 SAVE_REL: save_req=0 for exactly one cycle; then SHIFT if the shift counter is non-zero, else DONE.
REQ-023 SHIFT: left_req=1; same settle/fin rule using synchronized left_fin; exit to SHIFT_REL.
REQ-024 SHIFT_REL: left_req=0 for exactly one cycle; decrement the shift counter; then SHIFT if the result is non-zero, else DONE.
REQ-025 save_req and left_req SHALL never be high together, and each SHALL be low for at least one cycle between consecutive commands.
REQ-026 DONE: the block SHALL capture reg_out into result, pulse the granted requester's done for one cycle, and return to IDLE; a new grant is possible in the following cycle.
REQ-027 If SAVE or SHIFT reaches Timeout cycles without completion, the block SHALL drop the request, pulse done and err for the granted requester, load result with 0, and return to IDLE via DONE.
REQ-028 shamt=0 SHALL perform the load only; shamt>=Width SHALL execute all shifts, producing result 0.
REQ-029 Requests that drop before their done pulse SHALL NOT abort an operation in progress; ungranted request changes SHALL have no effect.
REQ-030 Each operation SHALL take at least (shamt+1)*(Settle+1)+2 cycles from grant to done.

Reset
REQ-031 On rst high, asynchronously: FSM=IDLE; save_req, left_req, all done/err=0; reg_in, result, counters=0; synchronizers cleared; round-robin pointer set so A is favoured.
REQ-032 Reset asserted mid-operation SHALL drop any active register request immediately; no done pulse is issued for the interrupted operation.

Verification
REQ-033 Width=8, A: data 0x0B, shamt 2, register model settles in 1 cycle -> one save, two shifts, a_done pulse, result 0x2C, a_err=0.
REQ-034 A and B requested in the same cycle after reset -> A served first, then B; next simultaneous pair -> B's successor order alternates (A after B).
REQ-035 shamt=0, data 0xA5 -> save_req only, left_req never rises, result 0xA5.
REQ-036 Register model never raises left_fin -> after Timeout cycles left_req drops, done and err pulse together, result 0.
REQ-037 rst asserted during SHIFT -> save_req/left_req low in the same cycle, no done, next request starts a fresh load.
REQ-038 Check on every cycle: save_req and left_req never both high; each has a low cycle between rising edges.
